// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
//   Shared definitions for the load/store unit:
//     - RV32I load/store funct3 encodings (F3_B/H/W/BU/HU)
//     - lsu_state_t FSM state enumeration
//     - helpers that classify an access and select the byte lanes a store
//       touches inside its 32-bit word
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_RD,
        ST_WRITE,
        ST_RESP
    } lsu_state_t;

    function automatic logic f3_is_byte(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_BU);
    endfunction

    function automatic logic f3_is_half(input logic [2:0] f3);
        return (f3 == F3_H) || (f3 == F3_HU);
    endfunction

    // Illegal funct3 for the direction, or an address not aligned to the
    // access size. Unsigned variants only exist for loads.
    function automatic logic access_fault(input logic       is_store,
                                          input logic [2:0] f3,
                                          input logic [1:0] addr_lo);
        logic legal;
        logic misaligned;
        case (f3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = !is_store;
            default:          legal = 1'b0;
        endcase
        case (f3[1:0])
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = |addr_lo;
            default: misaligned = 1'b0;
        endcase
        return !legal || misaligned;
    endfunction

    // True when byte lane 'lane' of the word is overwritten by a store.
    function automatic logic store_lane_sel(input logic [2:0] f3,
                                            input logic [1:0] addr_lo,
                                            input logic [1:0] lane);
        logic sel;
        if (f3_is_byte(f3)) begin
            sel = (addr_lo == lane);
        end else if (f3_is_half(f3)) begin
            sel = (addr_lo[1] == lane[1]);
        end else begin
            sel = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
//   Purely combinational data-path helper for the load/store unit.
//   Ports:
//     funct3       in   access type
//     addr_lo      in   byte address bits [1:0]
//     load_raw     in   memory read data; for byte/half accesses the memory
//                       already presents the addressed byte/half in the low bits
//     store_old    in   current word read back during read-modify-write
//     store_data   in   store operand (rs2)
//     load_ext     out  sign/zero-extended load result
//     store_merged out  store_old with the addressed byte/half lanes replaced
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] load_raw,
    input  logic [31:0] store_old,
    input  logic [31:0] store_data,
    output logic [31:0] load_ext,
    output logic [31:0] store_merged
);

    always_comb begin
        load_ext = load_raw;
        case (funct3)
            F3_B:    load_ext = {{24{load_raw[7]}},  load_raw[7:0]};
            F3_H:    load_ext = {{16{load_raw[15]}}, load_raw[15:0]};
            F3_BU:   load_ext = {24'h0, load_raw[7:0]};
            F3_HU:   load_ext = {16'h0, load_raw[15:0]};
            default: load_ext = load_raw;
        endcase
    end

    // Each byte lane picks its source byte from the store operand: SB
    // replicates byte 0, SH maps the low half onto whichever half is
    // addressed, SW is a straight copy.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_src;
            assign lane_src = f3_is_byte(funct3) ? store_data[7:0] :
                              f3_is_half(funct3) ? store_data[8*(gi%2) +: 8] :
                                                   store_data[8*gi +: 8];
            assign store_merged[8*gi +: 8] =
                store_lane_sel(funct3, addr_lo, 2'(gi)) ? lane_src
                                                        : store_old[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Blocking, single-outstanding load/store initiator for data_memory.
//   Loads are extended here; SB/SH are done as read-modify-write because
//   the memory only writes whole words.
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     req_valid/req_ready        request handshake (ready only when idle)
//     req_is_store, req_funct3,
//     req_addr, req_wdata        request payload, captured on accept
//     resp_valid                 one-cycle completion pulse
//     resp_rdata, resp_err       load result (0 for stores/errors), fault flag
//     mem_readAddr, mem_addr_byte,
//     mem_addr_half, mem_readData  memory read port (combinational read)
//     mem_writeAddr, mem_writeData,
//     mem_writeEn                memory word write port
//   Latency from accept to resp_valid: fault 1, load 2, SW 2, SB/SH 3.
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int BIT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [BIT_WIDTH-1:0]  req_wdata,
    output logic                  resp_valid,
    output logic [BIT_WIDTH-1:0]  resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_readAddr,
    output logic [ADDR_WIDTH-1:0] mem_writeAddr,
    output logic [BIT_WIDTH-1:0]  mem_writeData,
    output logic                  mem_writeEn,
    output logic                  mem_addr_byte,
    output logic                  mem_addr_half,
    input  logic [BIT_WIDTH-1:0]  mem_readData
);

    generate
        if (BIT_WIDTH != 32) begin : g_bad_width
            $error("load_store_unit: only BIT_WIDTH=32 is supported");
        end
    endgenerate

    lsu_state_t            state_reg;
    lsu_state_t            state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [2:0]            funct3_reg;
    logic                  is_store_reg;
    logic                  err_reg;
    // Holds store data on accept, the merged word after RMW_RD, and the
    // extended load result after LOAD.
    logic [BIT_WIDTH-1:0]  data_reg;

    logic                  accept;
    logic                  write_state;
    logic [31:0]           load_ext;
    logic [31:0]           store_merged;

    assign accept = req_valid && (state_reg == ST_IDLE);

    lsu_align u_align (
        .funct3       (funct3_reg),
        .addr_lo      (addr_reg[1:0]),
        .load_raw     (mem_readData),
        .store_old    (mem_readData),
        .store_data   (data_reg),
        .load_ext     (load_ext),
        .store_merged (store_merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            funct3_reg   <= '0;
            is_store_reg <= 1'b0;
            err_reg      <= 1'b0;
            data_reg     <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        addr_reg     <= req_addr;
                        funct3_reg   <= req_funct3;
                        is_store_reg <= req_is_store;
                        data_reg     <= req_wdata;
                        err_reg      <= access_fault(req_is_store, req_funct3,
                                                     req_addr[1:0]);
                    end
                end
                ST_LOAD:   data_reg <= load_ext;
                ST_RMW_RD: data_reg <= store_merged;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next    = state_reg;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        write_state   = 1'b0;
        mem_readAddr  = addr_reg;
        mem_addr_byte = 1'b0;
        mem_addr_half = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (access_fault(req_is_store, req_funct3, req_addr[1:0])) begin
                        state_next = ST_RESP;
                    end else if (!req_is_store) begin
                        state_next = ST_LOAD;
                    end else if (req_funct3 == F3_W) begin
                        state_next = ST_WRITE;
                    end else begin
                        state_next = ST_RMW_RD;
                    end
                end
            end
            ST_LOAD: begin
                mem_addr_byte = f3_is_byte(funct3_reg);
                mem_addr_half = f3_is_half(funct3_reg);
                state_next    = ST_RESP;
            end
            // Full-word read of the target word; flags stay low.
            ST_RMW_RD: state_next = ST_WRITE;
            ST_WRITE: begin
                write_state = 1'b1;
                state_next  = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = !reset;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign mem_writeAddr = {addr_reg[ADDR_WIDTH-1:2], 2'b00};
    assign mem_writeData = data_reg;
    // Gated by reset so a write already in its WRITE cycle is dropped.
    assign mem_writeEn   = write_state && !reset;

    assign resp_rdata = (resp_valid && !is_store_reg && !err_reg) ? data_reg : '0;
    assign resp_err   = resp_valid && err_reg;

endmodule
